data_memory_ctrl: RTL
=====================

// Module: data_memory_ctrl
// PURPOSE
//  Single-clock, parametrised data memory for the 16-bit CPU datapath; next generation of the
//  dual-clock data memory. Adds per-lane write masks, configurable registered read latency with
//  read_valid, write-first read-during-write forwarding, address range checking and a
//  hardware clear sequencer that initialises every word after reset or on request.
// PARAMETERS
//  DATA_WIDTH     16               word width; must be a multiple of LANE_WIDTH
//  LANE_WIDTH     8                bits per write-mask lane; LANES = DATA_WIDTH/LANE_WIDTH
//  ADDRESS_WIDTH  4                address bus width
//  DEPTH          1<<ADDRESS_WIDTH implemented words, 2..2**ADDRESS_WIDTH
//  READ_LATENCY   1                cycles from accepted read to read_valid; legal values 1 or 2
//  CLEAR_ON_RESET 1                1: run clear sequence after reset; 0: ready immediately
//  CLEAR_VALUE    0                word written to every location by the clear sequence
// PORTS
//  clock          in   1            rising-edge clock for all state
//  reset_n        in   1            asynchronous, active-low reset
//  Write_Enable   in   1            write request, sampled on the clock edge
//  write_address  in   ADDRESS_WIDTH write word address
//  write_mask     in   LANES        lane i writes DATA_WRITE[i*LANE_WIDTH +: LANE_WIDTH]
//  DATA_WRITE     in   DATA_WIDTH   write data
//  Read_Enable    in   1            read request, sampled on the clock edge
//  read_address   in   ADDRESS_WIDTH read word address
//  DATA_READ      out  DATA_WIDTH   read data; holds last value between reads
//  read_valid     out  1            one-cycle pulse, DATA_READ is valid for this read
//  clear_req      in   1            one-cycle pulse: start clear sequence (ignored while busy)
//  busy           out  1            clear sequence active; all requests ignored
//  addr_error     out  1            one-cycle pulse: accepted request hit address >= DEPTH
// BEHAVIOUR
//  Reset (reset_n=0, async): DATA_READ=0, read_valid=0, addr_error=0, pipeline cleared;
//   state=CLEAR and busy=1 if CLEAR_ON_RESET, else state=READY and busy=0. Array contents
//   are not reset asynchronously.
//  FSM: CLEAR -> READY when clear counter writes address DEPTH-1; READY -> CLEAR on
//   clear_req. In CLEAR one word per cycle, address 0 upward, CLEAR_VALUE written;
//   sequence length is exactly DEPTH cycles; busy deasserts on the cycle after the last write.
//  Reset asserted mid-clear aborts; the counter restarts at 0 after release.
//  While busy: Write_Enable, Read_Enable ignored (no write, no read_valid, no addr_error).
//  Write (READY): at edge with Write_Enable=1 and write_address<DEPTH, update masked lanes;
//   unmasked lanes are unchanged. write_mask=0 performs no write and raises no error.
//  Read (READY): accepted at edge with Read_Enable=1. READ_LATENCY=1: DATA_READ and
//   read_valid update on that same edge (visible the following cycle). READ_LATENCY=2:
//   one extra output register stage; a read is accepted every cycle (fully pipelined).
//  Read-during-write, same address, same edge: write-first; masked lanes return DATA_WRITE,
//   unmasked lanes return the stored value.
//  Out of range (address >= DEPTH, only if DEPTH<2**ADDRESS_WIDTH): write dropped; read
//   returns 0 with read_valid=1; addr_error pulses aligned with the accepting edge + 1 cycle.
//   Simultaneous bad read and bad write give a single addr_error pulse.
//  Reads issued before busy rises in the clear_req cycle still complete normally.
//  Pending pipeline reads complete even if clear_req arrives during their latency.
// TESTING
//  1 Reset, CLEAR_ON_RESET=1, DEPTH=16 -> busy=1 for exactly 16 cycles; then reading
//    every address returns 16'h0000 with one read_valid pulse per read.
//  2 Write addr 9 = 16'hC5A3, mask 2'b11; then write addr 9 = 16'h1100, mask 2'b10;
//    read 9 -> 16'h11A3, read_valid one cycle after the accepting edge (LATENCY=1).
//  3 Same edge: write addr 15 = 16'h0009, mask 2'b01 (stored 16'hFFFF); read 15 ->
//    16'hFF09 (write-first forwarding).
//  4 DEPTH=12: write addr 13 = 16'hBEEF -> addr_error pulse, array unchanged; read 13 ->
//    16'h0000, read_valid=1, addr_error=1.
//  5 READ_LATENCY=2: back-to-back reads addr 1,2,3 -> three consecutive read_valid cycles,
//    data in order, first valid 2 cycles after the first accept.
//  6 clear_req mid-run, reset_n low at clear step 5 -> after release busy lasts DEPTH cycles;
//    requests during busy produce no read_valid and no array change.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Single-clock data memory with per-lane write masks, write-first forwarding,
// range checking, 1/2-cycle registered read latency and a hardware clear sequencer.
module data_memory_ctrl #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned LANE_WIDTH     = 8,
    parameter int unsigned ADDRESS_WIDTH  = 4,
    parameter int unsigned DEPTH          = 1 << ADDRESS_WIDTH,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               Write_Enable,
    input  logic [ADDRESS_WIDTH-1:0]           write_address,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   write_mask,
    input  logic [DATA_WIDTH-1:0]              DATA_WRITE,
    input  logic                               Read_Enable,
    input  logic [ADDRESS_WIDTH-1:0]           read_address,
    output logic [DATA_WIDTH-1:0]              DATA_READ,
    output logic                               read_valid,
    input  logic                               clear_req,
    output logic                               busy,
    output logic                               addr_error
);

    localparam int unsigned LANES = DATA_WIDTH / LANE_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_W = (ADDRESS_WIDTH + 1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                   r_state;
    logic                     r_busy;
    logic [ADDRESS_WIDTH-1:0] r_clr_addr;
    logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
    logic                     r_s1_valid;
    logic [DATA_WIDTH-1:0]    r_s1_data;
    logic                     r_addr_err;

    logic                  w_ready;
    logic                  w_wr_req;
    logic                  w_wr_inr;
    logic                  w_wr_do;
    logic                  w_rd_acc;
    logic                  w_rd_inr;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_ready  = (r_state == ST_READY);
    assign w_wr_req = w_ready && Write_Enable && (|write_mask);
    assign w_wr_inr = {1'b0, write_address} < DEPTH_W;
    assign w_wr_do  = w_wr_req && w_wr_inr;
    assign w_rd_acc = w_ready && Read_Enable;
    assign w_rd_inr = {1'b0, read_address} < DEPTH_W;

    // Write-first: lanes being written this edge bypass the array
    always_comb begin
        w_rd_word = r_mem[read_address];
        w_rd_data = '0;
        if (w_rd_inr) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (w_wr_do && (write_address == read_address) && write_mask[l])
                    w_rd_data[l*LANE_WIDTH +: LANE_WIDTH] = DATA_WRITE[l*LANE_WIDTH +: LANE_WIDTH];
                else
                    w_rd_data[l*LANE_WIDTH +: LANE_WIDTH] = w_rd_word[l*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_addr] <= CLEAR_VALUE;
        end else if (w_wr_do) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (write_mask[l])
                    r_mem[write_address][l*LANE_WIDTH +: LANE_WIDTH] <= DATA_WRITE[l*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            r_busy     <= CLEAR_ON_RESET;
            r_clr_addr <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_addr == LAST_ADDR) begin
                        r_state    <= ST_READY;
                        r_busy     <= 1'b0;
                        r_clr_addr <= '0;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                ST_READY: begin
                    if (clear_req) begin
                        r_state    <= ST_CLEAR;
                        r_busy     <= 1'b1;
                        r_clr_addr <= '0;
                    end
                end
                default: r_state <= ST_READY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_s1_valid <= w_rd_acc;
            if (w_rd_acc)
                r_s1_data <= w_rd_data;
            r_addr_err <= (w_rd_acc && !w_rd_inr) || (w_wr_req && !w_wr_inr);
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_s2_valid;
            logic [DATA_WIDTH-1:0] r_s2_data;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid)
                        r_s2_data <= r_s1_data;
                end
            end

            assign DATA_READ  = r_s2_data;
            assign read_valid = r_s2_valid;
        end else begin : g_lat1
            assign DATA_READ  = r_s1_data;
            assign read_valid = r_s1_valid;
        end
    endgenerate

    assign busy       = r_busy;
    assign addr_error = r_addr_err;

endmodule
